// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl -- bit-serial A - B - Bin over WIDTH bits using one
// 1-bit full-subtractor step per clock, LSB first, borrow carried in a
// register between bits.
//
// Ports:
//   clk    system clock, all state on rising edge
//   rst    synchronous reset, active-high (aborts any operation)
//   start  request; only sampled in IDLE or DONE
//   a, b   minuend / subtrahend, captured on the accepted start edge
//   bin    borrow-in, captured on the accepted start edge
//   busy   high while the serial operation runs
//   done   one-cycle pulse, result flags valid
//   diff   registered difference, held until the next result
//   bout   final borrow-out (unsigned a < b + bin)
//   zero   diff == 0
//   ovf    two's-complement overflow
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sa, sb, res;
  logic             br;
  logic [CW-1:0]    cnt;

  // One full-subtractor step on the current operand LSB pair.
  logic             ak, bk, d, br_n, last;
  logic [WIDTH-1:0] res_n;

  assign ak    = sa[0];
  assign bk    = sb[0];
  assign d     = ak ^ bk ^ br;
  assign br_n  = (~ak & bk) | (~(ak ^ bk) & br);
  assign res_n = {d, res[WIDTH-1:1]};
  assign last  = (cnt == CW'(WIDTH - 1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last)  state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      res  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            br  <= bin;
            cnt <= '0;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          br  <= br_n;
          res <= res_n;
          cnt <= cnt + CW'(1);
          if (last) begin
            diff <= res_n;
            bout <= br_n;
            zero <= (res_n == '0);
            // On the last bit ak/bk are the captured operand MSBs and d is
            // the result MSB, so no separate copy of the signs is needed.
            ovf  <= (ak != bk) && (d != ak);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
